// File: rtl/transport_pkg.sv
// Shared codes for the transportSend arbiter slice.
// Command, owner and FSM state encodings.
package transport_pkg;

  localparam logic [1:0] CMD_NONE  = 2'b00;
  localparam logic [1:0] CMD_OPEN  = 2'b01;
  localparam logic [1:0] CMD_DATA  = 2'b10;
  localparam logic [1:0] CMD_CLOSE = 2'b11;

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_CTL  = 2'b01,
    OWN_AUD  = 2'b10
  } owner_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_ACK,
    S_WAIT_DONE
  } state_e;

endpackage

// File: rtl/transport_send_arbiter_busy_watchdog.sv
// busy_watchdog: loadable down-counter that flags a sender
// which never raises busy after a send strobe.
module busy_watchdog #(
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic clear,
  output logic expired
);

  localparam int CW = 16;

  logic [CW-1:0] cnt;
  logic          run;

  // Loaded with N-1 so expiry lands on the Nth waiting cycle.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
      run <= 1'b0;
    end else if (start) begin
      cnt <= CW'(ACK_TIMEOUT - 1);
      run <= 1'b1;
    end else if (run) begin
      if (cnt == '0) run <= 1'b0;
      else           cnt <= cnt - 16'd1;
    end
  end

  assign expired = run && (cnt == '0);

endmodule

// File: rtl/transport_send_arbiter.sv
// Round-robin arbiter sharing transportSend between control and audio.
// Define TRANSPORT_ARB_STATS_EN for grant/timeout statistics counters.
module transport_send_arbiter
  import transport_pkg::*;
#(
  parameter logic [1:0]  AUD_CMD     = 2'b10,
  parameter int unsigned ACK_TIMEOUT = 255,
  parameter int          TW          = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ctl_req,
  input  logic [1:0]    ctl_cmd,
  input  logic [TW-1:0] ctl_data,
  output logic          ctl_gnt,
  input  logic          aud_req,
  input  logic [TW-1:0] aud_data,
  output logic          aud_gnt,
  input  logic          ts_busy,
  output logic [1:0]    ts_cmd,
  output logic [TW-1:0] ts_data,
  output logic          ts_send,
  output logic [1:0]    owner,
  output logic          timeout_err
`ifdef TRANSPORT_ARB_STATS_EN
  ,
  output logic [15:0]   ctl_count,
  output logic [15:0]   aud_count,
  output logic [7:0]    to_count
`endif
);

  state_e        state_q, state_d;
  owner_e        own_q, own_d;
  owner_e        last_q, last_d;
  logic [1:0]    cmd_q, cmd_d;
  logic [TW-1:0] data_q, data_d;
  logic          wd_start, wd_clear, wd_expired;
  logic          ctl_v, pick_ctl;

  assign ctl_v    = ctl_req && (ctl_cmd != CMD_NONE);
  assign pick_ctl = ctl_v && (!aud_req || last_q == OWN_AUD);

  busy_watchdog #(
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) u_wd (
    .clk    (clk),
    .reset  (reset),
    .start  (wd_start),
    .clear  (wd_clear),
    .expired(wd_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      own_q   <= OWN_NONE;
      last_q  <= OWN_AUD;
      cmd_q   <= CMD_NONE;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      own_q   <= own_d;
      last_q  <= last_d;
      cmd_q   <= cmd_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    own_d       = own_q;
    last_d      = last_q;
    cmd_d       = cmd_q;
    data_d      = data_q;
    ts_send     = 1'b0;
    ctl_gnt     = 1'b0;
    aud_gnt     = 1'b0;
    timeout_err = 1'b0;
    wd_start    = 1'b0;
    wd_clear    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!ts_busy && (ctl_v || aud_req)) begin
          state_d = S_ISSUE;
          if (pick_ctl) begin
            cmd_d  = ctl_cmd;
            data_d = ctl_data;
            own_d  = OWN_CTL;
            last_d = OWN_CTL;
          end else begin
            cmd_d  = AUD_CMD;
            data_d = aud_data;
            own_d  = OWN_AUD;
            last_d = OWN_AUD;
          end
        end
      end
      S_ISSUE: begin
        ts_send  = 1'b1;
        ctl_gnt  = (own_q == OWN_CTL);
        aud_gnt  = (own_q == OWN_AUD);
        wd_start = 1'b1;
        state_d  = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (ts_busy) begin
          wd_clear = 1'b1;
          state_d  = S_WAIT_DONE;
        end else if (wd_expired) begin
          timeout_err = 1'b1;
          own_d       = OWN_NONE;
          cmd_d       = CMD_NONE;
          state_d     = S_IDLE;
        end
      end
      S_WAIT_DONE: begin
        if (!ts_busy) begin
          own_d   = OWN_NONE;
          cmd_d   = CMD_NONE;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign ts_cmd  = cmd_q;
  assign ts_data = data_q;
  assign owner   = own_q;

`ifdef TRANSPORT_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      ctl_count <= '0;
      aud_count <= '0;
      to_count  <= '0;
    end else begin
      if (ctl_gnt && ctl_count != 16'hffff)
        ctl_count <= ctl_count + 16'd1;
      if (aud_gnt && aud_count != 16'hffff)
        aud_count <= aud_count + 16'd1;
      if (timeout_err && to_count != 8'hff)
        to_count <= to_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_transport_send_arbiter.sv
// Bench for transport_send_arbiter: directed plan plus random traffic
// against a transaction-level model (TRANSPORT_ARB_STATS_EN optional).
module tb_transport_send_arbiter;

  localparam int T = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ctl_req = 1'b0;
  logic [1:0]  ctl_cmd = 2'b00;
  logic [15:0] ctl_data = '0;
  logic        ctl_gnt;
  logic        aud_req = 1'b0;
  logic [15:0] aud_data = '0;
  logic        aud_gnt;
  logic        ts_busy = 1'b0;
  logic [1:0]  ts_cmd;
  logic [15:0] ts_data;
  logic        ts_send;
  logic [1:0]  owner;
  logic        timeout_err;
`ifdef TRANSPORT_ARB_STATS_EN
  logic [15:0] ctl_count, aud_count;
  logic [7:0]  to_count;
`endif

  always #5 clk = ~clk;

  transport_send_arbiter #(
    .AUD_CMD    (2'b10),
    .ACK_TIMEOUT(T),
    .TW         (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ctl_req    (ctl_req),
    .ctl_cmd    (ctl_cmd),
    .ctl_data   (ctl_data),
    .ctl_gnt    (ctl_gnt),
    .aud_req    (aud_req),
    .aud_data   (aud_data),
    .aud_gnt    (aud_gnt),
    .ts_busy    (ts_busy),
    .ts_cmd     (ts_cmd),
    .ts_data    (ts_data),
    .ts_send    (ts_send),
    .owner      (owner),
    .timeout_err(timeout_err)
`ifdef TRANSPORT_ARB_STATS_EN
    ,
    .ctl_count  (ctl_count),
    .aud_count  (aud_count),
    .to_count   (to_count)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Transaction model: who holds the sender, and how long since the strobe
  int          m_own = 0;
  int          m_last = 2;
  int          m_age = 0;
  bit          m_acked = 0;
  logic [1:0]  m_cmd = 0;
  logic [15:0] m_data = 0;
  int          m_cc = 0, m_ac = 0, m_tc = 0;
  bit          chk_en = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_own = 0; m_last = 2; m_age = 0; m_acked = 0;
      m_cmd = 0; m_data = 0; m_cc = 0; m_ac = 0; m_tc = 0;
    end else if (m_own == 0) begin
      bit cv;
      cv = ctl_req && (ctl_cmd != 0);
      if (!ts_busy && (cv || aud_req)) begin
        if (cv && (!aud_req || m_last == 2)) begin
          m_own = 1; m_cmd = ctl_cmd; m_data = ctl_data;
        end else begin
          m_own = 2; m_cmd = 2'b10; m_data = aud_data;
        end
        m_last = m_own; m_age = 0; m_acked = 0;
      end
    end else if (m_age == 0) begin
      if (m_own == 1 && m_cc < 65535) m_cc++;
      if (m_own == 2 && m_ac < 65535) m_ac++;
      m_age = 1;
    end else if (!m_acked) begin
      if (ts_busy) m_acked = 1;
      else if (m_age == T) begin
        m_own = 0;
        if (m_tc < 255) m_tc++;
      end else m_age++;
    end else if (!ts_busy) begin
      m_own = 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      bit es;
      es = (m_own != 0) && (m_age == 0);
      chk("ts_send", ts_send, es);
      chk("ctl_gnt", ctl_gnt, es && m_own == 1);
      chk("aud_gnt", aud_gnt, es && m_own == 2);
      chk("owner", owner, m_own);
      chk("timeout_err", timeout_err,
          m_own != 0 && !m_acked && m_age == T && !ts_busy);
      if (m_own != 0) begin
        chk("ts_cmd", ts_cmd, m_cmd);
        chk("ts_data", ts_data, m_data);
      end
`ifdef TRANSPORT_ARB_STATS_EN
      chk("ctl_count", ctl_count, m_cc);
      chk("aud_count", aud_count, m_ac);
      chk("to_count", to_count, m_tc);
`endif
    end
  end

  // Sender emulation and requester agents, advanced once per cycle
  bit  rnd_en = 0;
  bit  resp_ack = 1;
  int  resp_lat = 1, resp_dur = 2;
  int  pend_lat = 0, busy_left = 0;
  bit  ext_busy = 0;
  int  c_left = 0, a_left = 0;
  bit  c_gf = 0, a_gf = 0;
  int  glog[$];
  logic [1:0] aud_cmd_seen = 0;

  task automatic tick();
    @(posedge clk);
    #1;
    if (pend_lat > 0) begin
      pend_lat--;
      if (pend_lat == 0) busy_left = resp_dur;
    end
    if (ts_send) begin
      if (rnd_en) begin
        resp_ack = ($urandom_range(0, 7) != 0);
        resp_lat = $urandom_range(1, 10);
        resp_dur = $urandom_range(0, 6);
      end
      if (resp_ack) pend_lat = resp_lat;
    end
    if (rnd_en) ext_busy = ($urandom_range(0, 11) == 0);
    if (rnd_en) begin
      reset = ($urandom_range(0, 399) == 0);
      if (reset) begin pend_lat = 0; busy_left = 0; end
    end
    ts_busy = ext_busy || (busy_left > 0);
    if (busy_left > 0) busy_left--;
    if (c_gf) begin
      if (c_left > 0) c_left--;
      if (c_left == 0) ctl_req = 0;
      else if (rnd_en) ctl_data = 16'($urandom);
    end
    if (a_gf) begin
      if (a_left > 0) a_left--;
      if (a_left == 0) aud_req = 0;
      else if (rnd_en) aud_data = 16'($urandom);
    end
    if (rnd_en) begin
      if (!ctl_req && $urandom_range(0, 7) == 0) begin
        ctl_req = 1; c_left = 1;
        ctl_cmd = 2'($urandom_range(0, 3));
        ctl_data = 16'($urandom);
      end else if (ctl_req && $urandom_range(0, 40) == 0) begin
        ctl_req = 0; c_left = 0;
      end else if (ctl_req && $urandom_range(0, 15) == 0) begin
        ctl_cmd = 2'($urandom_range(0, 3));
      end
      if (!aud_req && $urandom_range(0, 5) == 0) begin
        aud_req = 1; a_left = 1;
        aud_data = 16'($urandom);
      end else if (aud_req && $urandom_range(0, 40) == 0) begin
        aud_req = 0; a_left = 0;
      end
    end
    c_gf = ctl_gnt;
    a_gf = aud_gnt;
    if (ctl_gnt) glog.push_back(1);
    if (aud_gnt) begin
      glog.push_back(2);
      aud_cmd_seen = ts_cmd;
    end
  endtask

  task automatic do_reset();
    reset = 1;
    ctl_req = 0; aud_req = 0; c_left = 0; a_left = 0;
    pend_lat = 0; busy_left = 0; ext_busy = 0; ts_busy = 0;
    tick(); tick();
    reset = 0;
    glog.delete();
  endtask

  task automatic wait_send(string nm);
    int n = 0;
    while (!ts_send && n < 100) begin tick(); n++; end
    if (!ts_send) chk({nm, "_no_send"}, 0, 1);
  endtask

  task automatic wait_idle(string nm);
    int n = 0;
    while ((owner != 0 || c_left != 0 || a_left != 0) && n < 400) begin
      tick(); n++;
    end
    chk({nm, "_drain"}, (owner != 0 || c_left != 0 || a_left != 0), 0);
  endtask

  initial begin
    int n;
    int sends;
    tick(); tick();
    reset = 0;
    chk_en = 1;
    tick();
    chk("rst_owner", owner, 0);
    chk("rst_cmd", ts_cmd, 0);
    chk("rst_data", ts_data, 0);

    // 1: control only, sender busy for 20 cycles
    resp_ack = 1; resp_lat = 1; resp_dur = 20;
    ctl_req = 1; ctl_cmd = 2'b01; ctl_data = 16'h0044; c_left = 1;
    tick();
    chk("t1_send_lat", ts_send, 1);
    chk("t1_gnt", ctl_gnt, 1);
    tick();
    chk("t1_send_pulse", ts_send, 0);
    chk("t1_gnt_pulse", ctl_gnt, 0);
    chk("t1_cmd", ts_cmd, 2'b01);
    chk("t1_data", ts_data, 16'h0044);
    n = 1;
    while (owner != 0 && n < 60) begin tick(); n++; end
    chk("t1_len", n, 22);

    // 2: contention from the cycle after reset
    do_reset();
    resp_lat = 1; resp_dur = 2;
    ctl_req = 1; ctl_cmd = 2'b10; ctl_data = 16'h0001; c_left = 3;
    aud_req = 1; aud_data = 16'h1234; a_left = 3;
    wait_idle("t2");
    chk("t2_count", glog.size(), 6);
    for (int i = 0; i < 6; i++)
      if (i < glog.size()) chk("t2_order", glog[i], (i % 2 == 0) ? 1 : 2);
    chk("t2_aud_cmd", aud_cmd_seen, 2'b10);

    // 3: no acknowledge from the sender
    resp_ack = 0;
    aud_req = 1; aud_data = 16'hbeef; a_left = 1;
    wait_send("t3");
    n = 0;
    while (!timeout_err && n < 40) begin tick(); n++; end
    chk("t3_to_delay", n, T);
    tick();
    chk("t3_idle", owner, 0);
    resp_ack = 1;
    ctl_req = 1; ctl_cmd = 2'b11; ctl_data = 16'h5a5a; c_left = 1;
    wait_send("t3_next");
    chk("t3_next_gnt", ctl_gnt, 1);
    wait_idle("t3");

    // 4: invalid control command never arbitrates
    ctl_req = 1; ctl_cmd = 2'b00; ctl_data = 16'h7777; c_left = 1;
    sends = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      sends += ts_send;
    end
    chk("t4_no_send", sends, 0);
    aud_req = 1; aud_data = 16'h0abc; a_left = 1;
    wait_send("t4_aud");
    chk("t4_aud_gnt", aud_gnt, 1);
    n = 0;
    while (owner != 0 && n < 40) begin tick(); n++; end
    ctl_req = 0; c_left = 0;

    // 5: reset while the sender is mid-packet
    resp_lat = 1; resp_dur = 20;
    ctl_req = 1; ctl_cmd = 2'b01; ctl_data = 16'h0055; c_left = 1;
    wait_send("t5");
    for (int i = 0; i < 5; i++) tick();
    reset = 1; pend_lat = 0; busy_left = 0;
    tick();
    chk("t5_owner", owner, 0);
    chk("t5_cmd", ts_cmd, 0);
    chk("t5_data", ts_data, 0);
    chk("t5_send", ts_send, 0);
    ctl_req = 1; ctl_cmd = 2'b01; c_left = 1;
    aud_req = 1; a_left = 1;
    resp_dur = 2;
    tick();
    reset = 0;
    glog.delete();
    wait_idle("t5");
    chk("t5_first", (glog.size() > 0) ? glog[0] : 0, 1);

    // 6: statistics over a known grant/timeout mix
    do_reset();
    resp_ack = 1; resp_lat = 1; resp_dur = 2;
    ctl_req = 1; ctl_cmd = 2'b01; c_left = 3;
    aud_req = 1; a_left = 4;
    wait_idle("t6");
    resp_ack = 0;
    aud_req = 1; a_left = 1;
    n = 0;
    while (!timeout_err && n < 60) begin tick(); n++; end
    chk("t6_timeout_seen", timeout_err, 1);
    tick(); tick();
`ifdef TRANSPORT_ARB_STATS_EN
    chk("t6_ctl_count", ctl_count, 3);
    chk("t6_aud_count", aud_count, 5);
    chk("t6_to_count", to_count, 1);
`endif
    resp_ack = 1;

    // random traffic
    rnd_en = 1;
    for (int i = 0; i < 4000; i++) tick();
    rnd_en = 0;
    reset = 0; ext_busy = 0;
    ctl_req = 0; aud_req = 0; c_left = 0; a_left = 0;
    for (int i = 0; i < 40; i++) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
